aes_inv_sub_bytes_seq: RTL and testbench
========================================

Name: aes_inv_sub_bytes_seq

Overview:
- Iterative InvSubBytes stage for the AES decryption datapath. Sits directly downstream of the inverse-shift-rows stage.
- Accepts a 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through replicated inverse S-boxes.
- Presents the 128-bit result over a valid/ready handshake to the next stage (AddRoundKey / InvMixColumns).
- Trades area against latency: 16/BYTES_PER_CYCLE processing cycles per block.

Parameters:
- BYTES_PER_CYCLE, 4, inverse S-box instances. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- NUM_STEPS, 16/BYTES_PER_CYCLE, derived (localparam). Processing cycles per block.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream state valid.
- in_ready  output  1  block can accept a state this cycle.
- in_data  input  128  state, column-major; byte 0 = in_data[127:120], byte 15 = in_data[7:0].
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  substituted state, same byte ordering as in_data.
- busy  output  1  FSM in BUSY (status/debug).

Behaviour:
- Reset:
  - One clk edge with reset=1 forces state IDLE, step counter 0, data register 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset mid-BUSY or mid-DONE abandons the block; nothing is emitted.
- States: IDLE, BUSY, DONE. State is held in a 2-bit register and a step counter of clog2(NUM_STEPS)+1 bits.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the data register, set counter=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, chunk c = counter covers bytes c*BPC .. c*BPC+BPC-1 (byte 0 = MSB end).
  - Those bytes pass through the inverse S-boxes and are written back in place into the data register. Counter increments.
  - When counter==NUM_STEPS-1 is processed, go to DONE.
- DONE:
  - out_valid=1; out_data = data register, held stable while out_ready=0.
  - in_ready = out_ready, giving a pass-through accept.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: result retires and the new in_data is captured in the same edge. Counter=0, go to BUSY. Zero bubble between blocks.
- Latency: a state accepted at edge k gives out_valid=1 after edge k+NUM_STEPS.
- Throughput, back-to-back: one block per NUM_STEPS+1 cycles.
- Bytes already substituted are never re-substituted. The counter never exceeds NUM_STEPS-1 (no wrap).
- in_data is ignored whenever in_ready=0. out_data is only meaningful while out_valid=1, but the register is not cleared in IDLE.
- The inverse S-box is a pure 256-entry lookup of the FIPS-197 inverse table.

Optional Feature:
- Macro: AES_INV_SBOX_REG_EN.
- Defined:
  - A pipeline register is inserted after the S-box array; it captures chunk data and chunk index.
  - The write-back lands one cycle later.
  - BUSY lasts NUM_STEPS+1 cycles; latency is NUM_STEPS+1 and throughput is one block per NUM_STEPS+2 cycles.
  - DONE is entered only after the final chunk is written back.
- Undefined: purely combinational S-box path, timing as in Behaviour.
- Functional results are identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - AES_STATE_W=128 and AES_BYTE_W=8 constants.
  - The state FSM enum typedef {IDLE, BUSY, DONE}.
  - The inverse S-box table as a constant function/array.
  - A byte-index helper mapping byte n to bit slice [127-8n -: 8].
- One natural sub-module: aes_inv_sbox (8-bit in, 8-bit out, combinational), instantiated BYTES_PER_CYCLE times via generate.

Test Plan:
- Reset then idle: assert reset 2 cycles → in_ready=1, out_valid=0, out_data=0, busy=0.
- Basic substitution, BPC=4:
  - Stimulus: in_data=637c777bf26b6fc53001672bfed7ab76 accepted at edge k.
  - Required: out_valid=1 after edge k+4, out_data=000102030405060708090a0b0c0d0e0f.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_data stable, in_ready=0.
- Back-to-back:
  - Stimulus: in_data=63636363…63 waiting while the first block sits in DONE; raise out_ready.
  - Required: same-edge retire/accept; next result all 00 after 4 more cycles, no idle cycle inserted.
- Reset mid-BUSY: assert reset after 2 BUSY cycles → IDLE, out_valid never rises for that block, and the next block (all 00 in) yields all 52.
- Parameter sweep: BPC=1,16 with and without AES_INV_SBOX_REG_EN.
  - Latency is 16/17 and 1/2 cycles respectively.
  - Results match a scoreboard across 1000 random states.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
//   AES_STATE_W / AES_BYTE_W : state and byte widths
//   state_e                  : control FSM states of the iterative stages
//   INV_SBOX_TABLE           : inverse S-box, entry n at index n
//   inv_sbox()               : 8-bit inverse S-box lookup
//   state_byte()             : extract byte n of a state (byte 0 = MSB end)
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Inverse S-box, one 128-bit literal per table row (row = high nibble).
    localparam logic [0:255][7:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TABLE[b];
    endfunction

    function automatic logic [AES_BYTE_W-1:0] state_byte(
        input logic [AES_STATE_W-1:0] s,
        input int unsigned            n
    );
        return s[AES_STATE_W-1-AES_BYTE_W*n -: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/aes_inv_sub_bytes_seq_if.sv
// Stream interface of the InvSubBytes stage: 128-bit input and output
// states, each with a valid/ready handshake.
//   master : upstream/downstream side (drives in_*, out_ready)
//   slave  : the stage itself (drives in_ready, out_valid, out_data)
interface aes_inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational FIPS-197 inverse S-box.
//   din  : input byte
//   dout : substituted byte
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = inv_sbox(din);

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative InvSubBytes stage. A captured 128-bit state is substituted
// BYTES_PER_CYCLE bytes per clock (byte 0 first), in place, then held
// for the downstream stage. Accept in DONE is pass-through on out_ready,
// so blocks run back to back without an idle cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of the in/out valid-ready stream
//   busy       : high while chunks are being substituted
// Build option AES_INV_SBOX_REG_EN: registers the S-box outputs before
// write-back (one extra cycle per block, same results).
module aes_inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    aes_inv_sub_bytes_seq_if.slave  bus,
    output logic                    busy
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int STEP_W    = $clog2(NUM_STEPS) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_BUSY = 2'(BUSY);
    localparam logic [1:0] S_DONE = 2'(DONE);

    generate
        if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
            BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
            $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]             state_reg, state_next;
    logic [STEP_W-1:0]      step_reg, step_next;
    logic [AES_STATE_W-1:0] data_reg, data_next;
    logic [AES_STATE_W-1:0] wb_data;

    logic [7:0]             sbox_in  [BYTES_PER_CYCLE];
    logic [7:0]             sbox_out [BYTES_PER_CYCLE];
    logic [7:0]             wb_byte  [BYTES_PER_CYCLE];
    logic                   issue;      // chunk step_reg enters the S-boxes
    logic                   wb_valid;   // a substituted chunk lands this cycle
    logic [STEP_W-1:0]      wb_step;
    logic                   accept;

    assign bus.in_ready  = (state_reg == S_IDLE) || (state_reg == S_DONE && bus.out_ready);
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.out_data  = data_reg;
    assign busy          = (state_reg == S_BUSY);
    assign accept        = bus.in_valid && bus.in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
            assign sbox_in[gi] = state_byte(data_reg,
                                            int'(step_reg) * BYTES_PER_CYCLE + gi);
            aes_inv_sbox u_sbox (
                .din  (sbox_in[gi]),
                .dout (sbox_out[gi])
            );
        end

        // Each byte position is owned by a fixed chunk and lane.
        for (gi = 0; gi < 16; gi++) begin : g_wb
            localparam int CHUNK = gi / BYTES_PER_CYCLE;
            localparam int LANE  = gi % BYTES_PER_CYCLE;
            assign wb_data[AES_STATE_W-1-AES_BYTE_W*gi -: AES_BYTE_W] =
                (wb_valid && wb_step == STEP_W'(CHUNK)) ? wb_byte[LANE]
                : data_reg[AES_STATE_W-1-AES_BYTE_W*gi -: AES_BYTE_W];
        end
    endgenerate

`ifdef AES_INV_SBOX_REG_EN
    logic              pipe_valid_reg;
    logic [STEP_W-1:0] pipe_step_reg;
    logic [7:0]        pipe_byte_reg [BYTES_PER_CYCLE];
    logic              issue_en_reg;   // chunks remain to be issued

    assign issue    = (state_reg == S_BUSY) && issue_en_reg;
    assign wb_valid = pipe_valid_reg;
    assign wb_step  = pipe_step_reg;

    generate
        for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_pipe
            assign wb_byte[gi] = pipe_byte_reg[gi];
            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_byte_reg[gi] <= '0;
                end else if (issue) begin
                    pipe_byte_reg[gi] <= sbox_out[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_reg <= 1'b0;
            pipe_step_reg  <= '0;
            issue_en_reg   <= 1'b0;
        end else begin
            pipe_valid_reg <= issue;
            if (issue) begin
                pipe_step_reg <= step_reg;
            end
            if (accept) begin
                issue_en_reg <= 1'b1;
            end else if (issue && step_reg == LAST_STEP) begin
                issue_en_reg <= 1'b0;
            end
        end
    end
`else
    assign issue    = (state_reg == S_BUSY);
    assign wb_valid = issue;
    assign wb_step  = step_reg;

    generate
        for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_direct
            assign wb_byte[gi] = sbox_out[gi];
        end
    endgenerate
`endif

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        step_next  = step_reg;
        if (accept) begin
            step_next = '0;
        end else if (issue && step_reg != LAST_STEP) begin
            step_next = step_reg + 1'b1;
        end
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_BUSY;
                    data_next  = bus.in_data;
                end
            end
            S_BUSY: begin
                data_next = wb_data;
                if (wb_valid && wb_step == LAST_STEP) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_next = S_BUSY;
                        data_next  = bus.in_data;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            step_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            data_reg  <= data_next;
        end
    end

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Self-checking bench for aes_inv_sub_bytes_seq. Expected results come from
// an inverse S-box derived here from GF(2^8) arithmetic and the AES affine map.
module tb_aes_inv_sub_bytes_seq;

    parameter int BPC = 4;
`ifdef AES_INV_SBOX_REG_EN
    localparam int LAT = 16 / BPC + 1;
`else
    localparam int LAT = 16 / BPC;
`endif

    logic clk;
    logic reset;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] ref_inv [256];

    aes_inv_sub_bytes_seq_if bus ();

    aes_inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
        logic [7:0] inv = '0;
        logic [7:0] r;
        logic [7:0] s;
        for (int y = 1; y < 256; y++) begin
            if (v != 0 && gf_mul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s ^= r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] d);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) begin
            r[127-8*n -: 8] = ref_inv[d[127-8*n -: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE (pending=0) or DONE (pending=1).
    // Leaves the DUT in DONE holding the new result.
    task automatic run_block(input logic [127:0] d, input logic pending);
        logic [127:0] exp = ref_sub(d);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = pending;
        #1;
        chk("accept_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            #1;
            chk("busy_no_valid", 128'(bus.out_valid), 128'(0));
            chk("busy_flag", 128'(busy), 128'(1));
            chk("busy_in_ready", 128'(bus.in_ready), 128'(0));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = rand128();
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("done_valid", 128'(bus.out_valid), 128'(1));
        chk("result", bus.out_data, exp);
        chk("done_not_busy", 128'(busy), 128'(0));
        $display("block in=%h out=%h exp=%h pending=%0d", d, bus.out_data, exp, pending);
    endtask

    task automatic retire();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("retire_valid", 128'(bus.out_valid), 128'(0));
        chk("retire_ready", 128'(bus.in_ready), 128'(1));
        chk("retire_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        logic [127:0] held;
        logic         in_done;
        int           nb;

        for (int x = 0; x < 256; x++) ref_inv[fwd_sbox(8'(x))] = 8'(x);

        // Reset then idle
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data", bus.out_data, 128'h0);
        chk("rst_busy", 128'(busy), 128'(0));

        // Basic substitution against the FIPS forward-S-box outputs
        run_block(128'h637c777bf26b6fc53001672bfed7ab76, 1'b0);
        chk("basic_const", bus.out_data, 128'h000102030405060708090a0b0c0d0e0f);

        // Backpressure: result held while out_ready=0
        held = bus.out_data;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = rand128();
            @(negedge clk);
            #1;
            chk("bp_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_stable", bus.out_data, held);
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end

        // Back-to-back: same-edge retire and accept
        run_block({16{8'h63}}, 1'b1);
        chk("b2b_const", bus.out_data, 128'h0);
        retire();

        // Reset in the middle of BUSY
        bus.in_valid = 1'b1;
        bus.in_data  = rand128();
        @(negedge clk);
        bus.in_valid = 1'b0;
        nb = (LAT > 2) ? 2 : LAT - 1;
        for (int i = 0; i < nb; i++) begin
            #1;
            chk("mid_busy", 128'(busy), 128'(1));
            @(negedge clk);
        end
        #1;
        chk("mid_busy_pre_rst", 128'(busy), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mrst_busy", 128'(busy), 128'(0));
        chk("mrst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("mrst_out_data", bus.out_data, 128'h0);
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            #1;
            chk("mrst_no_emit", 128'(bus.out_valid), 128'(0));
        end
        run_block(128'h0, 1'b0);
        chk("post_rst_const", bus.out_data, {16{8'h52}});
        retire();

        // Random states, mixing idle gaps and back-to-back accepts
        in_done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (in_done && $urandom_range(0, 1) == 0) begin
                retire();
                in_done = 1'b0;
            end
            run_block(rand128(), in_done);
            in_done = 1'b1;
        end
        retire();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
